// File: rtl/if_stage_pkg.sv
// Shared widths, bus layouts and small helpers for the LoongArch32 instruction-fetch stage.
package if_stage_pkg;

  localparam int BR_BUS_WD       = 33;
  localparam int FS_TO_DS_BUS_WD = 64;

  localparam logic FS_READY_GO = 1'b1;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_bus_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF-side connection bundle: ID handshake, branch bus, instruction SRAM port and debug PC.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;
  logic [31:0]                debug_if_pc;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata, debug_if_pc
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata, debug_if_pc
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF next-PC select, IF register and a one-entry instruction
// buffer that keeps a fetched word alive across an ID stall without re-reading the SRAM.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic       clk,
  input  logic       resetn,
  if_stage_if.master pipe_io
);

  br_bus_t       br;
  fs_to_ds_bus_t to_ds_bus;
  logic [31:0]   nextpc;
  logic [31:0]   fs_inst;
  logic          fs_allowin;
  logic          fetch_req;
  logic          to_ds_valid;
  logic          to_ds_fire;
  logic          buf_load;
  logic          buf_clear;

  logic          to_fs_valid_q, to_fs_valid_d;
  logic          fs_valid_q,    fs_valid_d;
  logic [31:0]   fs_pc_q,       fs_pc_d;
  logic          data_fresh_q,  data_fresh_d;
  logic          buf_valid_q,   buf_valid_d;
  logic [31:0]   inst_buf_q,    inst_buf_d;

  // Next-PC select, handshake terms and next-state of every IF register.
  always_comb begin
    br          = br_bus_t'(pipe_io.br_bus);
    nextpc      = br.taken ? br.target : seq_pc(fs_pc_q);
    fs_allowin  = !fs_valid_q || (FS_READY_GO && pipe_io.ds_allowin) || br.taken;
    fetch_req   = to_fs_valid_q && fs_allowin;
    to_ds_valid = fs_valid_q && FS_READY_GO && !br.taken;
    to_ds_fire  = to_ds_valid && pipe_io.ds_allowin;

    // SRAM data only belongs to fs_pc the cycle after its request; capture it if ID can't take it.
    buf_load  = fs_valid_q && data_fresh_q && !buf_valid_q && !to_ds_fire && !br.taken;
    buf_clear = buf_valid_q && (to_ds_fire || br.taken);
    fs_inst   = buf_valid_q ? inst_buf_q : pipe_io.inst_sram_rdata;

    to_fs_valid_d = 1'b1;
    data_fresh_d  = fetch_req;

    if (fetch_req) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else begin
      fs_valid_d = fs_valid_q;
      fs_pc_d    = fs_pc_q;
    end

    if (buf_clear) begin
      buf_valid_d = 1'b0;
      inst_buf_d  = inst_buf_q;
    end else if (buf_load) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = pipe_io.inst_sram_rdata;
    end else begin
      buf_valid_d = buf_valid_q;
      inst_buf_d  = inst_buf_q;
    end

    to_ds_bus.inst = fs_inst;
    to_ds_bus.pc   = fs_pc_q;
  end

  // IF state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid_q <= 1'b0;
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= RESET_PC - 32'd4;
      data_fresh_q  <= 1'b0;
      buf_valid_q   <= 1'b0;
      inst_buf_q    <= 32'd0;
    end else begin
      to_fs_valid_q <= to_fs_valid_d;
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      data_fresh_q  <= data_fresh_d;
      buf_valid_q   <= buf_valid_d;
      inst_buf_q    <= inst_buf_d;
    end
  end

  assign pipe_io.fs_to_ds_valid  = to_ds_valid;
  assign pipe_io.fs_to_ds_bus    = to_ds_bus;
  assign pipe_io.inst_sram_en    = fetch_req;
  assign pipe_io.inst_sram_we    = 4'b0000;
  assign pipe_io.inst_sram_addr  = nextpc;
  assign pipe_io.inst_sram_wdata = 32'd0;
  assign pipe_io.debug_if_pc     = fs_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle vector table plus a scoreboard of PCs expected at ID.
module tb_if_stage;

  logic clk;
  logic resetn;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pipe_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'h0280_0421;
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  // SRAM model: data is only meaningful the cycle after an enabled read; otherwise garbage.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= 32'hdead_beef;
  end

  typedef struct packed {
    logic        da;
    logic        bt;
    logic [31:0] tgt;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic da, input logic bt, input logic [31:0] tgt,
                              input logic en, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
    vec_t v;
    v.da = da; v.bt = bt; v.tgt = tgt;
    v.exp_en = en; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc;
    return v;
  endfunction

  localparam int NV = 23;
  vec_t        vecs[NV];
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every transfer ID accepts must match the oldest expected PC.
  task automatic observe(input string tag);
    logic [31:0] pc;
    if (bus.fs_to_ds_valid && bus.ds_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s xfer: got unexpected pc %h expected no transfer", tag, bus.fs_to_ds_bus[31:0]);
      end else begin
        pc = exp_q.pop_front();
        chk({tag, " xfer"}, bus.fs_to_ds_bus, {mem_word(pc), pc});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0000, 1'b0, 32'h1bff_fffc);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0004, 1'b1, 32'h1c00_0000);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0008, 1'b1, 32'h1c00_0004);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_000c, 1'b1, 32'h1c00_0008);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_000c, 1'b1, 32'h1c00_0008);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_000c, 1'b1, 32'h1c00_0008);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_000c, 1'b1, 32'h1c00_0008);
    vecs[7]  = mk(1'b1, 1'b1, 32'h1c00_0100, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_000c);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0104, 1'b1, 32'h1c00_0100);
    vecs[9]  = mk(1'b0, 1'b1, 32'h1c00_0100, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_0104);
    vecs[10] = mk(1'b0, 1'b1, 32'h1c00_0100, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_0100);
    vecs[11] = mk(1'b0, 1'b1, 32'h1c00_0100, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_0100);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_0104, 1'b1, 32'h1c00_0100);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0104, 1'b1, 32'h1c00_0100);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_0108, 1'b1, 32'h1c00_0104);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_0108, 1'b1, 32'h1c00_0104);
    vecs[16] = mk(1'b0, 1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_0200, 1'b0, 32'h1c00_0104);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h1c00_0204, 1'b1, 32'h1c00_0200);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0204, 1'b1, 32'h1c00_0200);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h1c00_0208, 1'b1, 32'h1c00_0204);
    vecs[20] = mk(1'b1, 1'b1, 32'hffff_fffc, 1'b1, 32'hffff_fffc, 1'b0, 32'h1c00_0208);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hffff_fffc);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

    resetn         = 1'b0;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = 33'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 64'(bus.fs_to_ds_valid), 64'd0);
    chk("rst en",    64'(bus.inst_sram_en),   64'd0);
    chk("rst pc",    64'(bus.debug_if_pc),    64'h1bff_fffc);
    chk("we zero",   64'(bus.inst_sram_we),   64'd0);
    chk("wdata zero",64'(bus.inst_sram_wdata),64'd0);

    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      #1;
      bus.ds_allowin = vecs[i].da;
      bus.br_bus     = {vecs[i].bt, vecs[i].tgt};
      if (vecs[i].exp_valid && vecs[i].da) exp_q.push_back(vecs[i].exp_pc);
      @(negedge clk);
      chk($sformatf("r%0d en", i),    64'(bus.inst_sram_en),   64'(vecs[i].exp_en));
      chk($sformatf("r%0d addr", i),  64'(bus.inst_sram_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("r%0d valid", i), 64'(bus.fs_to_ds_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("r%0d pc", i),    64'(bus.debug_if_pc),    64'(vecs[i].exp_pc));
      if (vecs[i].exp_valid)
        chk($sformatf("r%0d bus", i), bus.fs_to_ds_bus, {mem_word(vecs[i].exp_pc), vecs[i].exp_pc});
      observe($sformatf("r%0d", i));
      @(posedge clk);
    end

    // Asynchronous reset landing between clock edges mid-run.
    #1;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = 33'd0;
    @(negedge clk);
    chk("pre-rst en", 64'(bus.inst_sram_en), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async valid", 64'(bus.fs_to_ds_valid), 64'd0);
    chk("async en",    64'(bus.inst_sram_en),   64'd0);
    chk("async pc",    64'(bus.debug_if_pc),    64'h1bff_fffc);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("restart en",   64'(bus.inst_sram_en),   64'd1);
    chk("restart addr", 64'(bus.inst_sram_addr), 64'h1c00_0000);
    chk("restart vld0", 64'(bus.fs_to_ds_valid), 64'd0);
    exp_q.push_back(32'h1c00_0000);
    @(posedge clk);
    #1;
    chk("restart vld1", 64'(bus.fs_to_ds_valid), 64'd1);
    chk("restart nxt",  64'(bus.inst_sram_addr), 64'h1c00_0004);
    observe("restart");

    chk("sb empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch32 pipeline; the upstream end of the fs->ds interface.
- Holds a pre-IF next-PC generator and the IF pipeline register.
- Drives the synchronous instruction SRAM (1-cycle read latency).
- Consumes ds_allowin and br_bus from ID; produces fs_to_ds_valid/fs_to_ds_bus.
- Includes a one-entry instruction buffer, so a fetched word survives a downstream stall without re-issuing the SRAM read.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset release.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_bus  in  `BR_BUS_WD (33)  {br_taken[32], br_target[31:0]} from ID
- fs_to_ds_valid  out  1  IF presents a valid instruction to ID
- fs_to_ds_bus  out  `FS_TO_DS_BUS_WD (64)  {fs_inst[63:32], fs_pc[31:0]}
- inst_sram_en  out  1  SRAM read request
- inst_sram_we  out  4  SRAM byte write enables, constant 0
- inst_sram_addr  out  32  SRAM address (nextpc)
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  SRAM read data, valid the cycle after an enabled request
- debug_if_pc  out  32  equals fs_pc

Behaviour:
- Reset (async, resetn=0):
  - to_fs_valid=0, fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0.
  - All outputs take their reset values immediately: fs_to_ds_valid=0, inst_sram_en=0, debug_if_pc=RESET_PC-4.
- to_fs_valid: register; 0 in reset, 1 from the first clk edge after release, stays 1.
- Pre-IF: nextpc = br_taken ? br_target : fs_pc+4 (32-bit, wraps modulo 2^32).
- fs_ready_go=1.
- fs_allowin = !fs_valid || (fs_ready_go && ds_allowin) || br_taken.
- inst_sram_en = to_fs_valid && fs_allowin; inst_sram_addr = nextpc.
- On each clk edge where inst_sram_en=1: fs_pc<=nextpc, fs_valid<=1; fs_valid clears only by reset.
- data_fresh register:
  - Set to 1 on the edge following an SRAM request, else 0.
  - inst_sram_rdata belongs to fs_pc only while data_fresh=1.
- Instruction buffer:
  - If fs_valid && data_fresh && !buf_valid && !(ds_allowin && fs_to_ds_valid) && !br_taken: inst_buf<=inst_sram_rdata, buf_valid<=1.
  - buf_valid clears on the edge where the instruction transfers to ID, or where br_taken=1.
- fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- fs_to_ds_valid = fs_valid && fs_ready_go && !br_taken.
  - Transfer to ID occurs when fs_to_ds_valid && ds_allowin.
  - A wrong-path instruction held in IF is discarded, never presented.
- Branch:
  - br_taken=1 in cycle t: request issued at br_target in t; IF holds br_target at t+1.
  - If br_taken stays high for several cycles (ID stalled), br_target is re-requested each cycle.
  - Only the request made after br_taken deasserts is delivered, so the target reaches ID exactly once.
- Stall: ds_allowin=0 with fs_valid=1 and br_taken=0:
  - inst_sram_en=0.
  - fs_pc, fs_to_ds_bus, fs_to_ds_valid all stable, even if inst_sram_rdata changes.
- No misaligned-PC or exception handling in this block.

Decomposition:
- mycpu_head.v supplies `FS_TO_DS_BUS_WD (64) and `BR_BUS_WD (33), shared with id_stage.
- RESET_PC is a parameter, not a define.
- No sub-module: the buffer is a few registers inline; a single flat module.

Test Plan:
- Reset release: resetn 0->1 → first inst_sram_en with addr 0x1c000000. Next cycle: fs_to_ds_valid=1, bus={rdata,0x1c000000}. Following request addr 0x1c000004. With ds_allowin=1 throughout, one instruction per cycle.
- Stall: IF holds 0x1c000008 (inst 0x02800421); ds_allowin=0 for 3 cycles while the bench drives rdata=0xdeadbeef → inst_sram_en=0. Bus stays {0x02800421,0x1c000008}. Delivered once when ds_allowin=1, then 0x1c00000c follows.
- Branch: br_bus={1,0x1c000100} while IF holds 0x1c00000c → fs_to_ds_valid=0 that cycle; inst_sram_addr=0x1c000100. Next cycle fs_pc=0x1c000100 and valid. 0x1c00000c is never transferred.
- Held branch: br_taken=1 for 3 cycles with ds_allowin=0 → 0x1c000100 requested each cycle, fs_to_ds_valid=0 throughout. After deassert, 0x1c000100 reaches ID exactly once.
- Branch with buffer full: stall until buf_valid=1, then br_taken=1 → buf_valid=0 next cycle. The delivered inst is the target's rdata, not the stale buffer.
- Async reset mid-run: resetn low between edges → fs_to_ds_valid and inst_sram_en drop to 0 combinationally. After release, fetch restarts at 0x1c000000.
